// File: rtl/rsa_pkg.sv
// Shared definitions for the systolic array feeder: FSM encoding, default element
// width and the sizing helpers used by the feeder top level.
package rsa_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int RSA_DW_DEF = 32;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed for a counter that must hold every value 0..v.
  function automatic int cnt_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/rsa_skew_line.sv
// Fixed-depth delay line: DEPTH registered stages, shifts every cycle, no stall input.
// Output is the last register, so latency is exactly DEPTH cycles.
module rsa_skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         sys_rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/rsa_skew_feeder.sv
// Feeds one k-slice per transfer into the PE array edges; lane i/j lags by i+1/j+1 cycles.
// in_ready is high only in FEED (no buffering); FLUSH drains max(X,Y) cycles then pulses done.
module rsa_skew_feeder
  import rsa_pkg::*;
#(
  parameter int X      = 4,
  parameter int Y      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = RSA_DW_DEF
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [cnt_w(L)-1:0]   len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [X*RSA_DW-1:0]   A_in,
  input  logic [Y*RSA_DW-1:0]   B_in,
  output logic [X*RSA_DW-1:0]   A_data,
  output logic [Y*RSA_DW-1:0]   B_data,
  output logic [Y-1:0]          new_cal_en,
  output logic [Y-1:0]          new_cal_done,
  output logic                  busy,
  output logic                  done
);

  localparam int D  = max2(X, Y);
  localparam int LW = cnt_w(L);
  localparam int FW = cnt_w(D - 1);

  logic [1:0]    state;
  logic [LW-1:0] n;
  logic [LW-1:0] k;
  logic [FW-1:0] fcnt;
  logic          xfer;
  logic          xfer_last;

  assign in_ready  = (state == ST_FEED);
  assign busy      = (state == ST_FEED) || (state == ST_FLUSH);
  assign done      = (state == ST_FLUSH) && (fcnt == FW'(D - 1));
  assign xfer      = in_valid && in_ready;
  assign xfer_last = xfer && (k == n - LW'(1));

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      n     <= '0;
      k     <= '0;
      fcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (len != '0)) begin
            state <= ST_FEED;
            n     <= (len > LW'(L)) ? LW'(L) : len;
            k     <= '0;
          end
        end
        ST_FEED: begin
          if (xfer) begin
            k <= k + 1'b1;
            if (xfer_last) begin
              state <= ST_FLUSH;
              fcnt  <= '0;
            end
          end
        end
        ST_FLUSH: begin
          if (fcnt == FW'(D - 1)) state <= ST_IDLE;
          else                    fcnt  <= fcnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Non-transfer cycles push zeros so bubbles travel down every lane with cal_en low.
  for (genvar i = 0; i < X; i++) begin : g_a
    logic [RSA_DW-1:0] a_lane;
    assign a_lane = xfer ? A_in[i*RSA_DW +: RSA_DW] : '0;
    rsa_skew_line #(.DEPTH(i + 1), .W(RSA_DW)) u_line (
      .clk     (clk),
      .sys_rst (sys_rst),
      .din     (a_lane),
      .dout    (A_data[i*RSA_DW +: RSA_DW])
    );
  end

  for (genvar j = 0; j < Y; j++) begin : g_b
    logic [RSA_DW-1:0] b_lane;
    logic [1:0]        stb;
    assign b_lane = xfer ? B_in[j*RSA_DW +: RSA_DW] : '0;
    rsa_skew_line #(.DEPTH(j + 1), .W(RSA_DW)) u_line (
      .clk     (clk),
      .sys_rst (sys_rst),
      .din     (b_lane),
      .dout    (B_data[j*RSA_DW +: RSA_DW])
    );
    rsa_skew_line #(.DEPTH(j + 1), .W(2)) u_stb (
      .clk     (clk),
      .sys_rst (sys_rst),
      .din     ({xfer_last, xfer}),
      .dout    (stb)
    );
    assign new_cal_en[j]   = stb[0];
    assign new_cal_done[j] = stb[1];
  end

endmodule

// File: tb/tb_rsa_skew_feeder.sv
// Directed bench for rsa_skew_feeder (X=Y=L=4, 32-bit elements).
// Cycle c is the interval after edge t0+c-1, where t0 is the edge of the first transfer.
module tb_rsa_skew_feeder;

  localparam int X  = 4;
  localparam int Y  = 4;
  localparam int L  = 4;
  localparam int DW = 32;
  localparam int D  = 4;

  logic                clk;
  logic                sys_rst;
  logic                start;
  logic [2:0]          len;
  logic                in_valid;
  logic                in_ready;
  logic [X*DW-1:0]     A_in;
  logic [Y*DW-1:0]     B_in;
  logic [X*DW-1:0]     A_data;
  logic [Y*DW-1:0]     B_data;
  logic [Y-1:0]        new_cal_en;
  logic [Y-1:0]        new_cal_done;
  logic                busy;
  logic                done;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected transfer edges (offset from t0) of each accepted slice, plus drive patterns.
  int   xk [8];
  int   nx;
  logic vpat [16];
  logic spat [16];
  int   sent;

  rsa_skew_feeder #(.X(X), .Y(Y), .L(L), .RSA_DW(DW)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .len          (len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A_in         (A_in),
    .B_in         (B_in),
    .A_data       (A_data),
    .B_data       (B_data),
    .new_cal_en   (new_cal_en),
    .new_cal_done (new_cal_done),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] a_val(input int k, input int i);
    return DW'(16 * k + i);
  endfunction

  function automatic logic [DW-1:0] b_val(input int k, input int j);
    return DW'(100 + 16 * k + j);
  endfunction

  function automatic logic [X*DW-1:0] a_slice(input int k);
    logic [X*DW-1:0] v;
    v = '0;
    for (int i = 0; i < X; i++) v[i*DW +: DW] = a_val(k, i);
    return v;
  endfunction

  function automatic logic [Y*DW-1:0] b_slice(input int k);
    logic [Y*DW-1:0] v;
    v = '0;
    for (int j = 0; j < Y; j++) v[j*DW +: DW] = b_val(k, j);
    return v;
  endfunction

  function automatic logic [X*DW-1:0] exp_a(input int c);
    logic [X*DW-1:0] v;
    v = '0;
    for (int k = 0; k < nx; k++)
      for (int i = 0; i < X; i++)
        if (xk[k] + 1 + i == c) v[i*DW +: DW] = a_val(k, i);
    return v;
  endfunction

  function automatic logic [Y*DW-1:0] exp_b(input int c);
    logic [Y*DW-1:0] v;
    v = '0;
    for (int k = 0; k < nx; k++)
      for (int j = 0; j < Y; j++)
        if (xk[k] + 1 + j == c) v[j*DW +: DW] = b_val(k, j);
    return v;
  endfunction

  // {cal_en, cal_done, done, busy, in_ready} expected in cycle c.
  function automatic logic [2*Y+2:0] exp_ctl(input int c);
    logic [Y-1:0] en;
    logic [Y-1:0] dn;
    int           last;
    en   = '0;
    dn   = '0;
    last = xk[nx-1];
    for (int k = 0; k < nx; k++)
      for (int j = 0; j < Y; j++)
        if (xk[k] + 1 + j == c) begin
          en[j] = 1'b1;
          if (k == nx - 1) dn[j] = 1'b1;
        end
    return {en, dn, (c == last + D), (c <= last + D), (c <= last)};
  endfunction

  task automatic clear_pat();
    for (int c = 0; c < 16; c++) begin
      vpat[c] = 1'b0;
      spat[c] = 1'b0;
    end
    sent = 0;
  endtask

  task automatic drive_edge(input int c);
    if (c < 16 && vpat[c]) begin
      in_valid = 1'b1;
      A_in     = a_slice(sent);
      B_in     = b_slice(sent);
      sent++;
    end else begin
      in_valid = 1'b0;
      A_in     = '0;
      B_in     = '0;
    end
    start = (c < 16) ? spat[c] : 1'b0;
    len   = 3'd4;
  endtask

  task automatic start_job(input logic [2:0] l);
    @(negedge clk);
    start    = 1'b1;
    len      = l;
    in_valid = 1'b0;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      len      = 3'($urandom);
      A_in     = {$urandom, $urandom, $urandom, $urandom};
      B_in     = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    n_chk++;
    if (A_data !== '0) begin
      n_fail++;
      $display("FAIL reset A_data got %h exp 0", A_data);
    end
    n_chk++;
    if (B_data !== '0) begin
      n_fail++;
      $display("FAIL reset B_data got %h exp 0", B_data);
    end
    n_chk++;
    if ({new_cal_en, new_cal_done, done, busy, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset ctl got %b exp 0", {new_cal_en, new_cal_done, done, busy, in_ready});
    end
    sys_rst  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    A_in     = '0;
    B_in     = '0;
    @(negedge clk);
    n_chk++;
    if ({busy, in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle busy/in_ready got %b exp 00", {busy, in_ready});
    end
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    start    = 1'b1;
    len      = 3'd0;
    in_valid = 1'b1;
    A_in     = a_slice(5);
    B_in     = b_slice(5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_chk++;
      if ({busy, in_ready, new_cal_en} !== '0 || A_data !== '0) begin
        n_fail++;
        $display("FAIL len_zero c=%0d busy/rdy/en got %b A %h exp all 0", c, {busy, in_ready, new_cal_en}, A_data);
      end
    end
    in_valid = 1'b0;
    A_in     = '0;
    B_in     = '0;
  endtask

  task automatic test_basic();
    clear_pat();
    for (int c = 0; c < 4; c++) vpat[c] = 1'b1;
    nx = 4;
    for (int k = 0; k < 4; k++) xk[k] = k;
    start_job(3'd4);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      n_chk++;
      if (A_data !== exp_a(c)) begin
        n_fail++;
        $display("FAIL basic A_data c=%0d got %h exp %h", c, A_data, exp_a(c));
      end
      n_chk++;
      if (B_data !== exp_b(c)) begin
        n_fail++;
        $display("FAIL basic B_data c=%0d got %h exp %h", c, B_data, exp_b(c));
      end
      n_chk++;
      if ({new_cal_en, new_cal_done, done, busy, in_ready} !== exp_ctl(c)) begin
        n_fail++;
        $display("FAIL basic ctl c=%0d got %b exp %b", c, {new_cal_en, new_cal_done, done, busy, in_ready}, exp_ctl(c));
      end
      drive_edge(c);
    end
  endtask

  task automatic test_bubbles();
    clear_pat();
    vpat[0] = 1'b1;
    vpat[3] = 1'b1;
    vpat[4] = 1'b1;
    nx = 3;
    xk[0] = 0;
    xk[1] = 3;
    xk[2] = 4;
    start_job(3'd3);
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) @(negedge clk);
      n_chk++;
      if (A_data !== exp_a(c)) begin
        n_fail++;
        $display("FAIL bubbles A_data c=%0d got %h exp %h", c, A_data, exp_a(c));
      end
      n_chk++;
      if (B_data !== exp_b(c)) begin
        n_fail++;
        $display("FAIL bubbles B_data c=%0d got %h exp %h", c, B_data, exp_b(c));
      end
      n_chk++;
      if ({new_cal_en, new_cal_done, done, busy, in_ready} !== exp_ctl(c)) begin
        n_fail++;
        $display("FAIL bubbles ctl c=%0d got %b exp %b", c, {new_cal_en, new_cal_done, done, busy, in_ready}, exp_ctl(c));
      end
      drive_edge(c);
    end
  endtask

  task automatic test_len_clamp();
    clear_pat();
    for (int c = 0; c < 5; c++) vpat[c] = 1'b1;
    nx = 4;
    for (int k = 0; k < 4; k++) xk[k] = k;
    start_job(3'd7);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      n_chk++;
      if (A_data !== exp_a(c)) begin
        n_fail++;
        $display("FAIL len_clamp A_data c=%0d got %h exp %h", c, A_data, exp_a(c));
      end
      n_chk++;
      if ({new_cal_en, new_cal_done, done, busy, in_ready} !== exp_ctl(c)) begin
        n_fail++;
        $display("FAIL len_clamp ctl c=%0d got %b exp %b", c, {new_cal_en, new_cal_done, done, busy, in_ready}, exp_ctl(c));
      end
      drive_edge(c);
    end
  endtask

  task automatic test_reset_mid();
    clear_pat();
    for (int c = 0; c < 4; c++) vpat[c] = 1'b1;
    nx = 2;
    xk[0] = 0;
    xk[1] = 1;
    start_job(3'd4);
    drive_edge(0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_chk++;
      if (A_data !== exp_a(c)) begin
        n_fail++;
        $display("FAIL reset_mid pre A_data c=%0d got %h exp %h", c, A_data, exp_a(c));
      end
      drive_edge(c);
    end
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst  = 1'b0;
    in_valid = 1'b0;
    A_in     = '0;
    B_in     = '0;
    for (int c = 3; c <= 10; c++) begin
      n_chk++;
      if (A_data !== '0 || B_data !== '0 || {new_cal_en, new_cal_done, done, busy, in_ready} !== '0) begin
        n_fail++;
        $display("FAIL reset_mid post c=%0d A %h B %h ctl %b exp all 0", c, A_data, B_data, {new_cal_en, new_cal_done, done, busy, in_ready});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    clear_pat();
    for (int c = 0; c < 4; c++) vpat[c] = 1'b1;
    spat[1] = 1'b1;
    spat[7] = 1'b1;
    nx = 4;
    for (int k = 0; k < 4; k++) xk[k] = k;
    start_job(3'd4);
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) @(negedge clk);
      n_chk++;
      if (A_data !== exp_a(c)) begin
        n_fail++;
        $display("FAIL start_ignored A_data c=%0d got %h exp %h", c, A_data, exp_a(c));
      end
      n_chk++;
      if ({new_cal_en, new_cal_done, done, busy, in_ready} !== exp_ctl(c)) begin
        n_fail++;
        $display("FAIL start_ignored ctl c=%0d got %b exp %b", c, {new_cal_en, new_cal_done, done, busy, in_ready}, exp_ctl(c));
      end
      drive_edge(c);
    end
  endtask

  initial begin
    sys_rst  = 1'b1;
    start    = 1'b0;
    len      = 3'd0;
    in_valid = 1'b0;
    A_in     = '0;
    B_in     = '0;
    test_reset();
    test_len_zero();
    test_basic();
    test_bubbles();
    test_len_clamp();
    test_reset_mid();
    test_basic();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

endmodule
